sftm_group_engine: RTL and testbench
====================================

// Module: sftm_group_engine
// PURPOSE
//  Parametrised successor of the SFTM group producer. Accepts a channel-interleaved word stream,
//  sequences it into groups of cfg_rows x cfg_cols x N_CH words, optionally requantises each word
//  (rounding arithmetic shift with saturation), and emits it on a valid/ready stream.
//  Each word carries channel/column/row tags. Sits between the PosTA output and the QMU.
// PARAMETERS
//  DATA_W    16  word width (signed, two's complement)
//  N_CH      4   channels interleaved per column (>=1)
//  MAX_ROWS  16  max rows per group (>=1)
//  MAX_COLS  64  max columns per row (>=1)
//  SHIFT_W   4   width of requantisation shift amount
// PORTS
//  clk          in   1                         clock
//  rst          in   1                         async active-high reset
//  start        in   1                         pulse: latch cfg_*, begin group (honoured only in IDLE)
//  bypass_mode  in   1                         latched at start: 1 = pass data unmodified
//  cfg_rows     in   clog2(MAX_ROWS+1)         rows per group; 0 treated as 1, >MAX_ROWS clamped
//  cfg_cols     in   clog2(MAX_COLS+1)         columns per row; 0 treated as 1, >MAX_COLS clamped
//  cfg_shift    in   SHIFT_W                   right-shift amount, normal mode
//  in_valid     in   1                         input word valid
//  in_ready     out  1                         input word accepted when in_valid&&in_ready
//  in_data      in   DATA_W                    input word
//  out_valid    out  1                         output word valid
//  out_ready    in   1                         downstream accept
//  out_data     out  DATA_W                    output word
//  out_ch       out  clog2(N_CH) (min 1)       channel tag
//  out_col      out  clog2(MAX_COLS) (min 1)   column tag
//  out_row      out  clog2(MAX_ROWS) (min 1)   row tag
//  out_last     out  1                         last word of group
//  group_busy   out  1                         high from start-accept until group_done
//  group_done   out  1                         1-cycle pulse when out_last word is accepted
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  - Reset: all outputs 0; state IDLE; counters 0. Reset mid-group discards it; no group_done.
//  States:
//  - IDLE: start -> RUN. Latch cfg and bypass; clear ch/col/row counters; group_busy <= 1.
//  - RUN: accepts N_CH*cols*rows input words, then -> FLUSH.
//  - FLUSH: waits for the last output to be accepted; pulses group_done; -> IDLE next cycle.
//  - start outside IDLE is ignored. cfg_* and bypass_mode changes are ignored after the latch.
//  Counters and tags:
//  - Tags are the counter values at input accept.
//  - ch increments per accepted word and wraps N_CH-1 -> 0, carrying into col.
//  - col wraps cols-1 -> 0, carrying into row.
//  - out_last = (ch==N_CH-1 && col==cols-1 && row==rows-1).
//  Handshake:
//  - Single output register. in_ready = (state==RUN) && (!out_valid || out_ready).
//  - Latency: a word accepted at edge k is visible on out_* after edge k, i.e. 1 cycle.
//  - Full throughput when out_ready stays 1.
//  - out_* hold stable while out_valid && !out_ready. out_valid never drops without acceptance.
//  - Accept and emit in the same cycle is allowed (register reload).
//  - in_ready is 0 in IDLE and FLUSH. Words offered then are not consumed.
//  Arithmetic:
//  - bypass=1: out_data = in_data.
//  - bypass=0, shift=0: out_data = in_data.
//  - bypass=0, shift=s>0: r = (in_data + 2^(s-1)) >>> s, computed in DATA_W+1 bits.
//    Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Shifts >= DATA_W give 0 or -1 by sign.
//  Boundary cases:
//  - rows=cols=N_CH=1: single-word group; out_last on that word.
//  - group_done and a new start on the same cycle: start ignored (state not yet IDLE).
// TESTING
//  1. Basic: rows=2, cols=3, bypass=1, N_CH=4, out_ready=1, data 0..23.
//     -> 24 outputs; out_data=in_data; tags walk ch0..3/col0..2/row0..1.
//     -> out_last only on word 23; group_done 1 cycle after it; group_busy falls with done.
//  2. Requant: bypass=0, shift=2, inputs 5, -5, 6, 0x7FFF.
//     -> outputs 1, -1, 2, 0x2000. With shift=0, input 0x7FFF -> 0x7FFF.
//  3. Saturation: DATA_W=16, shift=1, input 0x7FFF -> 0x4000 (no overflow).
//     Force shift=15 on 0x7FFF -> 1; on 0x8000 -> 0xFFFF.
//  4. Backpressure: toggle out_ready random 50% over a 2x2 group.
//     -> no loss or duplication; out_data stable while stalled; in_ready=0 whenever out_valid&&!out_ready.
//  5. Config edges: cfg_rows=0, cfg_cols=0 -> 1x1xN_CH group.
//     start pulsed mid-RUN -> ignored, tags unaffected.
//  6. Reset mid-group: assert rst after 5 words -> all outputs 0 immediately, no group_done.
//     Next start runs a clean group from tag 0.

Source files
------------

// File: rtl/sftm_group_engine.sv
// Group sequencer for the SFTM path. It tags a channel-interleaved word stream with
// channel, column and row, optionally requantises each word, and emits it on valid/ready.
`timescale 1ns/1ps
module sftm_group_engine #(
  parameter int DATA_W   = 16,
  parameter int N_CH     = 4,
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 64,
  parameter int SHIFT_W  = 4,
  localparam int RW   = $clog2(MAX_ROWS + 1),
  localparam int CW   = $clog2(MAX_COLS + 1),
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int COLW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1,
  localparam int ROWW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bypass_mode,
  input  logic [RW-1:0]     cfg_rows,
  input  logic [CW-1:0]     cfg_cols,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHW-1:0]    out_ch,
  output logic [COLW-1:0]   out_col,
  output logic [ROWW-1:0]   out_row,
  output logic              out_last,
  output logic              group_busy,
  output logic              group_done
);

  // Valid/ready: a word moves on any rising edge where valid && ready are both high;
  // a producer holding valid keeps its payload stable until that edge.

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  localparam logic signed [DATA_W:0] SMAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SMIN = {2'b11, {(DATA_W-1){1'b0}}};

  logic               bypass_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [RW-1:0]      rows_q;
  logic [CW-1:0]      cols_q;
  logic [CHW-1:0]     ch_cnt;
  logic [COLW-1:0]    col_cnt;
  logic [ROWW-1:0]    row_cnt;

  logic start_fire, in_fire, out_fire;
  logic ch_last, col_last, row_last, word_last;
  logic [RW-1:0] rows_eff;
  logic [CW-1:0] cols_eff;

  assign start_fire = (state == IDLE) && start;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  assign ch_last   = (ch_cnt == CHW'(N_CH - 1));
  assign col_last  = (CW'(col_cnt) == cols_q - CW'(1));
  assign row_last  = (RW'(row_cnt) == rows_q - RW'(1));
  assign word_last = ch_last && col_last && row_last;

  always_comb begin
    rows_eff = cfg_rows;
    if (cfg_rows == '0) rows_eff = RW'(1);
    else if (cfg_rows > RW'(MAX_ROWS)) rows_eff = RW'(MAX_ROWS);
    cols_eff = cfg_cols;
    if (cfg_cols == '0) cols_eff = CW'(1);
    else if (cfg_cols > CW'(MAX_COLS)) cols_eff = CW'(MAX_COLS);
  end

  // Rounding arithmetic right shift; the sum is formed one bit wider so +half cannot wrap.
  function automatic logic [DATA_W-1:0] requant(input logic [DATA_W-1:0] d,
                                                input logic [SHIFT_W-1:0] s);
    logic signed [DATA_W:0] ext, rnd, shr;
    logic [DATA_W-1:0] res;
    ext = $signed({d[DATA_W-1], d});
    rnd = '0;
    shr = '0;
    res = d;
    if (s != '0) begin
      if (32'(s) >= DATA_W) begin
        res = d[DATA_W-1] ? '1 : '0;
      end else begin
        rnd = $signed({{DATA_W{1'b0}}, 1'b1} << (s - SHIFT_W'(1)));
        shr = (ext + rnd) >>> s;
        if (shr > SMAX) res = SMAX[DATA_W-1:0];
        else if (shr < SMIN) res = SMIN[DATA_W-1:0];
        else res = shr[DATA_W-1:0];
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (in_fire && word_last) state_nxt = FLUSH;
      FLUSH:   if (out_fire && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == RUN) && (!out_valid || out_ready);
    group_busy = (state == RUN) || (state == FLUSH);
    group_done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q <= 1'b0;
      shift_q  <= '0;
      rows_q   <= RW'(1);
      cols_q   <= CW'(1);
      ch_cnt   <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
    end else if (start_fire) begin
      bypass_q <= bypass_mode;
      shift_q  <= cfg_shift;
      rows_q   <= rows_eff;
      cols_q   <= cols_eff;
      ch_cnt   <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
    end else if (in_fire) begin
      if (ch_last) begin
        ch_cnt <= '0;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + ROWW'(1);
        end else begin
          col_cnt <= col_cnt + COLW'(1);
        end
      end else begin
        ch_cnt <= ch_cnt + CHW'(1);
      end
    end
  end

  // Single output register: reloads on accept, otherwise drops valid only once taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= bypass_q ? in_data : requant(in_data, shift_q);
      out_ch    <= ch_cnt;
      out_col   <= col_cnt;
      out_row   <= row_cnt;
      out_last  <= word_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sftm_group_engine.sv
// Directed bench for sftm_group_engine: the driver pushes hand-computed expected words
// into a queue, and a monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_sftm_group_engine;
  localparam int DATA_W = 16, N_CH = 4, MAX_ROWS = 16, MAX_COLS = 64, SHIFT_W = 4;
  localparam int RW = 5, CW = 7, CHW = 2, COLW = 6, ROWW = 4;
  localparam int EW = DATA_W + CHW + COLW + ROWW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic bypass_mode = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [CW-1:0] cfg_cols = '0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [CHW-1:0] out_ch;
  logic [COLW-1:0] out_col;
  logic [ROWW-1:0] out_row;
  logic out_last, group_busy, group_done;

  sftm_group_engine #(.DATA_W(DATA_W), .N_CH(N_CH), .MAX_ROWS(MAX_ROWS),
                      .MAX_COLS(MAX_COLS), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bypass_mode(bypass_mode),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_col(out_col), .out_row(out_row), .out_last(out_last),
    .group_busy(group_busy), .group_done(group_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  int  g_rows = 1, g_cols = 1;
  int  done_cnt = 0;
  int  groups_exp = 0;
  bit  exp_done = 1'b0;
  bit  bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Downstream ready: constant 1 unless backpressure is enabled.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic stall_p;
    logic [EW-1:0] held, got, e;
    stall_p = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {out_data, out_ch, out_col, out_row, out_last};
      if (rst) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_hold", 32'(got), 32'(held));
        end
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          held = got;
          stall_p = 1'b1;
        end else begin
          stall_p = 1'b0;
        end
        if (group_done || exp_done) begin
          check("group_done", 32'(group_done), 32'(exp_done));
          if (group_done) begin
            check("busy_at_done", 32'(group_busy), 32'd0);
            done_cnt++;
          end
          exp_done = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %0h with empty expected queue", got);
          end else begin
            e = exp_q.pop_front();
            check("out_word", 32'(got), 32'(e));
            if (e[0]) exp_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_group(input int rows, input int cols, input bit byp,
                             input int shift, input int eff_rows, input int eff_cols);
    cfg_rows = RW'(rows);
    cfg_cols = CW'(cols);
    bypass_mode = byp;
    cfg_shift = SHIFT_W'(shift);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    g_rows = eff_rows;
    g_cols = eff_cols;
    groups_exp++;
    check("busy_after_start", 32'(group_busy), 32'd1);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e, input int idx);
    int total;
    bit ok;
    logic [EW-1:0] ex;
    total = N_CH * g_cols * g_rows;
    ok = 1'b0;
    ex = {e, CHW'(idx % N_CH), COLW'((idx / N_CH) % g_cols),
          ROWW'(idx / (N_CH * g_cols)), 1'(idx == total - 1)};
    in_valid = 1'b1;
    in_data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word %0d not accepted, in_ready=%0b", idx, in_ready);
    end else begin
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!group_busy && !group_done && !out_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, 32'(ok), 32'd1);
    check({name, "_done_count"}, 32'(done_cnt), 32'(groups_exp));
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_data"}, 32'(out_data), 32'd0);
    check({name, "_tags"}, 32'({out_ch, out_col, out_row, out_last}), 32'd0);
    check({name, "_busy_done"}, 32'({group_busy, group_done}), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    bit seen;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Words offered in IDLE must not be consumed.
    in_valid = 1'b1;
    in_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // 1: basic bypass group, 2 rows x 3 cols x 4 ch; start on the done cycle is ignored.
    start_group(2, 3, 1'b1, 5, 2, 3);
    for (int i = 0; i < 24; i++) send(16'(i), 16'(i), i);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (group_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("basic_done_seen", 32'(seen), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_on_done_busy", 32'(group_busy), 32'd0);
    @(negedge clk);
    check("start_on_done_in_ready", 32'(in_ready), 32'd0);
    wait_idle("basic");

    // 2: requant, shift 2 then shift 0.
    start_group(1, 1, 1'b0, 2, 1, 1);
    send(16'd5,    16'd1,    0);
    send(16'hFFFB, 16'hFFFF, 1);
    send(16'd6,    16'd2,    2);
    send(16'h7FFF, 16'h2000, 3);
    wait_idle("requant2");
    start_group(1, 1, 1'b0, 0, 1, 1);
    send(16'h7FFF, 16'h7FFF, 0);
    send(16'h8000, 16'h8000, 1);
    send(16'h0001, 16'h0001, 2);
    send(16'hFFFF, 16'hFFFF, 3);
    wait_idle("requant0");

    // 3: rounding at the extremes, shift 1 and shift 15.
    start_group(1, 1, 1'b0, 1, 1, 1);
    send(16'h7FFF, 16'h4000, 0);
    send(16'h8000, 16'hC000, 1);
    send(16'h0003, 16'h0002, 2);
    send(16'hFFFD, 16'hFFFF, 3);
    wait_idle("sat1");
    start_group(1, 1, 1'b0, 15, 1, 1);
    send(16'h7FFF, 16'h0001, 0);
    send(16'h8000, 16'hFFFF, 1);
    send(16'h4000, 16'h0001, 2);
    send(16'h3FFF, 16'h0000, 3);
    wait_idle("sat15");

    // 4: random backpressure over a 2x2 group; bypass overrides the shift.
    bp_en = 1'b1;
    start_group(2, 2, 1'b1, 3, 2, 2);
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 16'h0100 + 16'(i), i);
    wait_idle("backpressure");
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // 5: zero config -> 1x1; start mid-RUN must not reload cfg or counters.
    start_group(0, 0, 1'b0, 1, 1, 1);
    send(16'd10, 16'd5, 0);
    send(16'd3,  16'd2, 1);
    cfg_rows = 5'd2;
    cfg_cols = 7'd2;
    bypass_mode = 1'b1;
    cfg_shift = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send(16'd7,    16'd4,    2);
    send(16'hFFF9, 16'hFFFD, 3);
    wait_idle("cfg_zero");

    // Column clamp: 100 columns requested, 64 used.
    start_group(1, 100, 1'b1, 0, 1, 64);
    for (int i = 0; i < 256; i++) send(16'(i * 3), 16'(i * 3), i);
    wait_idle("col_clamp");

    // 6: reset after 5 words discards the group without group_done.
    start_group(2, 3, 1'b1, 0, 2, 3);
    for (int i = 0; i < 5; i++) send(16'h0A00 + 16'(i), 16'h0A00 + 16'(i), i);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    exp_done = 1'b0;
    groups_exp--;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_reset_no_done", 32'(done_cnt), 32'(groups_exp));
    start_group(1, 1, 1'b1, 0, 1, 1);
    for (int i = 0; i < 4; i++) send(16'h0B00 + 16'(i), 16'h0B00 + 16'(i), i);
    wait_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
